// File: rtl/vga_timing_gen_if.sv
`timescale 1ns/1ps
// Pixel-stream bundle shared by every stage of the video pipeline.
// Carries one beat per pixel clock: raster position, syncs, blanks and colour.
// No flow control: the stream is free-running at the pixel rate.
interface vga_if #(
    parameter int CNT_W = 11
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [11:0]      rgb;

    // Producer side of the stream.
    modport out (
        output hcount,
        output vcount,
        output hsync,
        output vsync,
        output hblnk,
        output vblnk,
        output rgb
    );

    // Consumer side of the stream.
    modport in (
        input hcount,
        input vcount,
        input hsync,
        input vsync,
        input hblnk,
        input vblnk,
        input rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// VGA raster timing source: free-running h/v counters with registered sync/blank decode.
// Latency: none; counters and all decoded fields update on the same clock edge.
// Backpressure: none; the stream advances one pixel every clock unconditionally.
module vga_timing_gen #(
    parameter int   H_ACTIVE     = 800,
    parameter int   H_SYNC_START = 840,
    parameter int   H_SYNC_END   = 968,
    parameter int   H_TOTAL      = 1056,
    parameter int   V_ACTIVE     = 600,
    parameter int   V_SYNC_START = 601,
    parameter int   V_SYNC_END   = 605,
    parameter int   V_TOTAL      = 628,
    parameter logic HSYNC_POL    = 1'b1,
    parameter logic VSYNC_POL    = 1'b1,
    parameter int   CNT_W        = 11
) (
    input  logic clk,
    input  logic rst,
    vga_if.out   out,
    output logic frame_start,
    output logic line_start
);

    // ------------------------------------------------------------------
    // Elaboration-time legality of the raster geometry
    // ------------------------------------------------------------------
    localparam longint CNT_RANGE = longint'(1) << CNT_W;

    localparam bit H_LEGAL = (H_ACTIVE > 0)                  &&
                             (H_ACTIVE <= H_SYNC_START)      &&
                             (H_SYNC_START < H_SYNC_END)     &&
                             (H_SYNC_END <= H_TOTAL)         &&
                             (longint'(H_TOTAL) <= CNT_RANGE);

    localparam bit V_LEGAL = (V_ACTIVE > 0)                  &&
                             (V_ACTIVE <= V_SYNC_START)      &&
                             (V_SYNC_START < V_SYNC_END)     &&
                             (V_SYNC_END <= V_TOTAL)         &&
                             (longint'(V_TOTAL) <= CNT_RANGE);

    generate
        if (!H_LEGAL) begin : g_bad_h_geometry
            $fatal(1, "vga_timing_gen: illegal horizontal timing parameters");
        end
        if (!V_LEGAL) begin : g_bad_v_geometry
            $fatal(1, "vga_timing_gen: illegal vertical timing parameters");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Window bounds may legally equal 2^CNT_W (e.g. H_SYNC_END == H_TOTAL
    // == 2^CNT_W), which does not fit in CNT_W bits. Compares are therefore
    // done one bit wider so such a bound never truncates to zero.
    typedef logic [CNT_W:0] cmp_t;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    localparam cmp_t H_ACT_X = cmp_t'(H_ACTIVE);
    localparam cmp_t H_SS_X  = cmp_t'(H_SYNC_START);
    localparam cmp_t H_SE_X  = cmp_t'(H_SYNC_END);
    localparam cmp_t V_ACT_X = cmp_t'(V_ACTIVE);
    localparam cmp_t V_SS_X  = cmp_t'(V_SYNC_START);
    localparam cmp_t V_SE_X  = cmp_t'(V_SYNC_END);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] h_d;
    logic [CNT_W-1:0] v_q;
    logic [CNT_W-1:0] v_d;

    logic hsync_q;
    logic hsync_d;
    logic vsync_q;
    logic vsync_d;
    logic hblnk_q;
    logic hblnk_d;
    logic vblnk_q;
    logic vblnk_d;
    logic line_start_q;
    logic line_start_d;
    logic frame_start_q;
    logic frame_start_d;

    cmp_t h_x;
    cmp_t v_x;

    // Next raster position: horizontal wraps every line, vertical steps on that wrap.
    always_comb begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + CNT_W'(1);
            end
        end
    end

    // Decode the windows from the next position so the registered fields line up with the registered counters.
    always_comb begin
        h_x           = {1'b0, h_d};
        v_x           = {1'b0, v_d};
        hblnk_d       = (h_x >= H_ACT_X);
        vblnk_d       = (v_x >= V_ACT_X);
        hsync_d       = ((h_x >= H_SS_X) && (h_x < H_SE_X)) ? HSYNC_POL : ~HSYNC_POL;
        // v_d only moves together with the h wrap, so vsync can only change on h==0 beats.
        vsync_d       = ((v_x >= V_SS_X) && (v_x < V_SE_X)) ? VSYNC_POL : ~VSYNC_POL;
        line_start_d  = (h_d == '0);
        frame_start_d = (h_d == '0) && (v_d == '0);
    end

    // Register counters and decodes together; reset parks the raster at (0,0) with syncs inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: every field comes straight from a register of the same edge.
    // Colour is black here; later draw stages overwrite it.
    // ------------------------------------------------------------------
    assign out.hcount  = h_q;
    assign out.vcount  = v_q;
    assign out.hsync   = hsync_q;
    assign out.vsync   = vsync_q;
    assign out.hblnk   = hblnk_q;
    assign out.vblnk   = vblnk_q;
    assign out.rgb     = 12'h000;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen: three geometries (800x600 default, a tiny raster with
// active-low syncs, 640x480) each compared beat by beat against an arithmetic
// raster model indexed by the number of clocks since reset release.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def   = 1'b1;
    logic rst_small = 1'b1;
    logic rst_vga   = 1'b1;

    logic fs_def, ls_def, fs_small, ls_small, fs_vga, ls_vga;

    vga_if #(.CNT_W(11)) if_def   ();
    vga_if #(.CNT_W(11)) if_small ();
    vga_if #(.CNT_W(11)) if_vga   ();

    vga_timing_gen u_def (
        .clk(clk), .rst(rst_def), .out(if_def),
        .frame_start(fs_def), .line_start(ls_def)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_SYNC_START(22), .H_SYNC_END(25), .H_TOTAL(30),
        .V_ACTIVE(10), .V_SYNC_START(11), .V_SYNC_END(13), .V_TOTAL(16),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(11)
    ) u_small (
        .clk(clk), .rst(rst_small), .out(if_small),
        .frame_start(fs_small), .line_start(ls_small)
    );

    vga_timing_gen #(
        .H_ACTIVE(640), .H_SYNC_START(656), .H_SYNC_END(752), .H_TOTAL(800),
        .V_ACTIVE(480), .V_SYNC_START(490), .V_SYNC_END(492), .V_TOTAL(525),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(11)
    ) u_vga (
        .clk(clk), .rst(rst_vga), .out(if_vga),
        .frame_start(fs_vga), .line_start(ls_vga)
    );

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        fs;
        logic        ls;
    } beat_t;

    typedef struct {
        int   ha, hss, hse, ht;
        int   va, vss, vse, vt;
        logic hpol, vpol;
    } geo_t;

    geo_t geo [3];

    beat_t obs_def, obs_small, obs_vga;
    assign obs_def   = {if_def.hcount, if_def.vcount, if_def.hsync, if_def.vsync,
                        if_def.hblnk, if_def.vblnk, if_def.rgb, fs_def, ls_def};
    assign obs_small = {if_small.hcount, if_small.vcount, if_small.hsync, if_small.vsync,
                        if_small.hblnk, if_small.vblnk, if_small.rgb, fs_small, ls_small};
    assign obs_vga   = {if_vga.hcount, if_vga.vcount, if_vga.hsync, if_vga.vsync,
                        if_vga.hblnk, if_vga.vblnk, if_vga.rgb, fs_vga, ls_vga};

    int tests = 0;
    int fails = 0;

    function automatic beat_t obs_of(int k);
        case (k)
            0:       return obs_def;
            1:       return obs_small;
            default: return obs_vga;
        endcase
    endfunction

    task automatic set_rst(int k, logic val);
        case (k)
            0:       rst_def   = val;
            1:       rst_small = val;
            default: rst_vga   = val;
        endcase
    endtask

    // Raster model: position is simply elapsed clocks modulo line / frame length.
    // n == 0 is the reset-state beat, which carries no start pulses.
    function automatic beat_t model(int k, longint n);
        beat_t  b;
        geo_t   g;
        longint line;
        int     h;
        int     v;
        g    = geo[k];
        line = n / g.ht;
        h    = int'(n % g.ht);
        v    = int'(line % g.vt);
        b.h   = 11'(h);
        b.v   = 11'(v);
        b.hb  = (h >= g.ha);
        b.vb  = (v >= g.va);
        b.hs  = (h >= g.hss && h < g.hse) ? g.hpol : ~g.hpol;
        b.vs  = (v >= g.vss && v < g.vse) ? g.vpol : ~g.vpol;
        b.rgb = 12'h000;
        b.ls  = (n != 0) && (h == 0);
        b.fs  = b.ls && (v == 0);
        return b;
    endfunction

    // Hold reset a few clocks, release on a falling edge; the current beat is then n=0.
    task automatic reset_release(int k);
        @(negedge clk);
        set_rst(k, 1'b1);
        repeat ($urandom_range(2, 4)) @(negedge clk);
        set_rst(k, 1'b0);
    endtask

    task automatic test_reset();
        beat_t o, e;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_rst(k, 1'b1);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            o = obs_of(k); e = model(k, 0);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset_hold inst=%0d got=%h exp=%h", k, o, e);
            end
            set_rst(k, 1'b0);
            o = obs_of(k);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL release_beat inst=%0d got=%h exp=%h", k, o, e);
            end
            @(negedge clk);
            o = obs_of(k); e = model(k, 1);
            tests++;
            if (o !== e || o.h !== 11'd1 || o.v !== 11'd0) begin
                fails++;
                $display("FAIL first_edge inst=%0d got=%h exp=%h", k, o, e);
            end
        end
    endtask

    // Default 800x600: a few lines beat-checked, plus line-level landmarks.
    task automatic test_h_sweep();
        beat_t o, e;
        int    ncyc;
        int    hs_cnt = 0;
        int    first_hb = -1;
        int    first_ls = -1;
        int    printed = 0;
        reset_release(0);
        ncyc = 3 * 1056 + int'($urandom_range(0, 500));
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            o = obs_of(0); e = model(0, n);
            tests++;
            if (o !== e) begin
                fails++;
                if (printed < 8) begin
                    printed++;
                    $display("FAIL h_sweep n=%0d got=%h exp=%h", n, o, e);
                end
            end
            if (n < 1056 && o.hs === 1'b1) hs_cnt++;
            if (first_hb < 0 && o.hb === 1'b1) first_hb = n;
            if (first_ls < 0 && o.ls === 1'b1) first_ls = n;
        end
        tests++;
        if (hs_cnt !== 128) begin
            fails++;
            $display("FAIL hsync_width got=%0d exp=128", hs_cnt);
        end
        tests++;
        if (first_hb !== 800) begin
            fails++;
            $display("FAIL hblnk_rise got=%0d exp=800", first_hb);
        end
        tests++;
        if (first_ls !== 1056) begin
            fails++;
            $display("FAIL line_period got=%0d exp=1056", first_ls);
        end
    endtask

    // 640x480 with active-low syncs: two lines.
    task automatic test_vga640();
        beat_t o, e;
        int    hs_low = 0;
        int    first_hb = -1;
        int    printed = 0;
        reset_release(2);
        for (int n = 1; n <= 1600; n++) begin
            @(negedge clk);
            o = obs_of(2); e = model(2, n);
            tests++;
            if (o !== e) begin
                fails++;
                if (printed < 8) begin
                    printed++;
                    $display("FAIL vga640 n=%0d got=%h exp=%h", n, o, e);
                end
            end
            if (n < 800 && o.hs === 1'b0) hs_low++;
            if (first_hb < 0 && o.hb === 1'b1) first_hb = n;
        end
        tests++;
        if (hs_low !== 96) begin
            fails++;
            $display("FAIL vga640_hsync_width got=%0d exp=96", hs_low);
        end
        tests++;
        if (first_hb !== 640) begin
            fails++;
            $display("FAIL vga640_hblnk_rise got=%0d exp=640", first_hb);
        end
    endtask

    // Tiny raster (30x16): several full frames for vertical behaviour and frame period.
    task automatic test_frame();
        beat_t o, e, prev;
        int    ncyc;
        int    last_fs = -1;
        int    ls_in_frame = 0;
        int    vs_act = 0;
        int    first_vb = -1;
        int    n_fs = 0;
        int    printed = 0;
        reset_release(1);
        prev = obs_of(1);
        ncyc = 3 * 480 + int'($urandom_range(0, 200));
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            o = obs_of(1); e = model(1, n);
            tests++;
            if (o !== e) begin
                fails++;
                if (printed < 8) begin
                    printed++;
                    $display("FAIL frame_beat n=%0d got=%h exp=%h", n, o, e);
                end
            end
            if (o.vs !== prev.vs && o.h !== 11'd0) begin
                tests++;
                fails++;
                $display("FAIL vsync_mid_line n=%0d got_h=%0d exp_h=0", n, o.h);
            end
            if (o.ls === 1'b1) ls_in_frame++;
            if (n < 480 && o.vs === 1'b0) vs_act++;
            if (first_vb < 0 && o.vb === 1'b1) first_vb = n;
            if (o.fs === 1'b1) begin
                n_fs++;
                tests++;
                if (last_fs < 0) begin
                    if (n !== 480 || ls_in_frame !== 16) begin
                        fails++;
                        $display("FAIL first_frame got_n=%0d got_lines=%0d exp_n=480 exp_lines=16",
                                 n, ls_in_frame);
                    end
                end else if (n - last_fs !== 480 || ls_in_frame !== 16) begin
                    fails++;
                    $display("FAIL frame_period got=%0d got_lines=%0d exp=480 exp_lines=16",
                             n - last_fs, ls_in_frame);
                end
                last_fs = n;
                ls_in_frame = 0;
            end
            prev = o;
        end
        tests++;
        if (n_fs !== 3) begin
            fails++;
            $display("FAIL frame_count got=%0d exp=3", n_fs);
        end
        tests++;
        if (vs_act !== 60) begin
            fails++;
            $display("FAIL vsync_width got=%0d exp=60", vs_act);
        end
        tests++;
        if (first_vb !== 300) begin
            fails++;
            $display("FAIL vblnk_rise got=%0d exp=300", first_vb);
        end
    endtask

    // Reset dropped at a random mid-frame point: must clear without a clock edge, then restart from (0,0).
    task automatic test_mid_reset();
        beat_t o, e;
        int    r;
        int    printed = 0;
        for (int k = 0; k < 2; k++) begin
            reset_release(k);
            r = (k == 0) ? int'($urandom_range(200, 3000)) : int'($urandom_range(50, 400));
            for (int n = 1; n <= r; n++) begin
                @(negedge clk);
                o = obs_of(k); e = model(k, n);
                tests++;
                if (o !== e) begin
                    fails++;
                    if (printed < 8) begin
                        printed++;
                        $display("FAIL pre_reset inst=%0d n=%0d got=%h exp=%h", k, n, o, e);
                    end
                end
            end
            @(posedge clk);
            #2;
            set_rst(k, 1'b1);
            #2;
            o = obs_of(k); e = model(k, 0);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL async_reset inst=%0d got=%h exp=%h", k, o, e);
            end
            repeat (3) begin
                @(negedge clk);
                o = obs_of(k);
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL reset_held inst=%0d got=%h exp=%h", k, o, e);
                end
            end
            set_rst(k, 1'b0);
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                o = obs_of(k); e = model(k, n);
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL restart inst=%0d n=%0d got=%h exp=%h", k, n, o, e);
                end
            end
        end
    endtask

    initial begin
        geo[0] = '{800, 840, 968, 1056, 600, 601, 605, 628, 1'b1, 1'b1};
        geo[1] = '{20, 22, 25, 30, 10, 11, 13, 16, 1'b0, 1'b0};
        geo[2] = '{640, 656, 752, 800, 480, 490, 492, 525, 1'b0, 1'b0};
        repeat (3) @(negedge clk);
        test_reset();
        test_h_sweep();
        test_vga640();
        test_frame();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
